// File: rtl/uart_bus_master.sv
// UART command initiator: 'W'/'R' byte commands become single word accesses on the CPU bus. The strobe fires 1 cycle after the last rx byte.
// Replies are held on txchar/txvalid until txready; rx bytes arriving while a command is executing or replying are dropped.
module uart_bus_master #(
   parameter int ADDR_W  = 30,
   parameter int TIMEOUT = 5000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rxchar,
   input  logic              rxvalid,
   output logic [7:0]        txchar,
   output logic              txvalid,
   input  logic              txready,
   output logic              hold,
   output logic              re,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wdata,
   input  logic [31:0]       rdata
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, RCAP, TX, ACK} state_t;

   state_t        state;
   logic [1:0]    cnt;
   logic [TW-1:0] tcnt;
   logic          is_wr;
   logic [31:0]   shift;
   logic          tx_acc;

   assign tx_acc = txvalid && txready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         tcnt    <= '0;
         is_wr   <= 1'b0;
         shift   <= '0;
         txchar  <= '0;
         txvalid <= 1'b0;
         hold    <= 1'b0;
         re      <= 1'b0;
         we      <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
      end else begin
         re <= 1'b0;
         we <= 1'b0;
         case (state)
            IDLE: begin
               if (rxvalid) begin
                  hold <= 1'b1;
                  if (rxchar == 8'h57 || rxchar == 8'h52) begin
                     is_wr <= (rxchar == 8'h57);
                     cnt   <= '0;
                     tcnt  <= '0;
                     state <= ADDR;
                  end else begin
                     txchar  <= 8'h3F;
                     txvalid <= 1'b1;
                     state   <= ACK;
                  end
               end
            end
            ADDR, DATA: begin
               if (rxvalid) begin
                  tcnt <= '0;
                  cnt  <= cnt + 2'd1;
                  if (state == ADDR) addr  <= {addr[ADDR_W-9:0], rxchar};
                  else               wdata <= {wdata[23:0], rxchar};
                  if (cnt == 2'd3) begin
                     if (state == DATA) begin
                        we    <= 1'b1;
                        state <= WRITE;
                     end else if (is_wr) begin
                        state <= DATA;
                     end else begin
                        re    <= 1'b1;
                        state <= READ;
                     end
                  end
               end else if (tcnt == TW'(TIMEOUT)) begin
                  // host went quiet mid-command: abandon it without a reply
                  hold  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            WRITE: begin
               txchar  <= 8'h4B;
               txvalid <= 1'b1;
               state   <= ACK;
            end
            READ: state <= RCAP;
            RCAP: begin
               shift   <= rdata;
               txchar  <= rdata[31:24];
               txvalid <= 1'b1;
               cnt     <= '0;
               state   <= TX;
            end
            TX: begin
               if (tx_acc) begin
                  shift  <= {shift[23:0], 8'h00};
                  txchar <= shift[23:16];
                  cnt    <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     txvalid <= 1'b0;
                     hold    <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            ACK: begin
               if (tx_acc) begin
                  txvalid <= 1'b0;
                  hold    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
